// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared widths, MDU operation codes and op classification for the MDU issue controller.
package mdu_issue_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned RES_W  = 2 * DATA_W;

    localparam logic [OP_W-1:0] MDU_NOP       = 5'b00000;
    localparam logic [OP_W-1:0] MULT_CONTROL  = 5'b11000;
    localparam logic [OP_W-1:0] MULTU_CONTROL = 5'b11001;
    localparam logic [OP_W-1:0] DIV_CONTROL   = 5'b11010;
    localparam logic [OP_W-1:0] DIVU_CONTROL  = 5'b11011;

    // Divides are the only multi-cycle operations.
    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Execute-stage initiator for the multiply/divide unit: launches ops, holds divide
// operands, stalls the pipeline until the MDU is ready and owns the HI/LO registers.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              flush,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              mdu_en,
    output logic              mdu_clear,
    output logic [OP_W-1:0]   mdu_control,
    output logic [DATA_W-1:0] mdu_a,
    output logic [DATA_W-1:0] mdu_b,
    input  logic [RES_W-1:0]  mdu_result,
    input  logic              mdu_ready,
    output logic              stall_out,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    state_t            w_next;
    logic [OP_W-1:0]   w_ctl;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_en;
    logic              w_stall;
    logic              w_res_we;
    logic              w_launch;
    logic              w_mt_ok;

    // Next state, MDU drive, stall and write enables; stall and MDU drive must react
    // in the issue cycle, so these are combinational.
    always_comb begin
        w_next   = r_state;
        w_ctl    = MDU_NOP;
        w_a      = '0;
        w_b      = '0;
        w_en     = 1'b1;
        w_stall  = 1'b0;
        w_res_we = 1'b0;
        w_launch = 1'b0;
        w_mt_ok  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_mt_ok = ~flush;
                if (req_valid && !flush) begin
                    w_ctl = req_op;
                    w_a   = req_a;
                    w_b   = req_b;
                    if (is_div_op(req_op)) begin
                        w_launch = 1'b1;
                        w_stall  = 1'b1;
                        w_next   = ST_BUSY;
                    end else begin
                        // Multiplies answer combinationally: commit at this edge.
                        w_res_we = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                w_ctl = r_op;
                w_a   = r_a;
                w_b   = r_b;
                if (flush) begin
                    w_next = ST_IDLE;
                end else if (mdu_ready) begin
                    w_res_we = 1'b1;
                    w_next   = ST_DRAIN;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_DRAIN: begin
                // NOP for one cycle lets the divider drop its start and re-arm.
                w_en    = 1'b0;
                w_stall = req_valid;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign mdu_en      = w_en;
    assign mdu_clear   = flush;
    assign mdu_control = w_ctl;
    assign mdu_a       = w_a;
    assign mdu_b       = w_b;
    assign stall_out   = w_stall;
    assign hi_o        = r_hi;
    assign lo_o        = r_lo;

    // State register and divide operand latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= MDU_NOP;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_op <= req_op;
                r_a  <= req_a;
                r_b  <= req_b;
            end
        end
    end

    // HI/LO: an MDU result write takes precedence over MTHI/MTLO at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_res_we) begin
                r_hi <= mdu_result[RES_W-1:DATA_W];
            end else if (mthi_we && w_mt_ok) begin
                r_hi <= wdata;
            end
            if (w_res_we) begin
                r_lo <= mdu_result[DATA_W-1:0];
            end else if (mtlo_we && w_mt_ok) begin
                r_lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl with a behavioural MDU (combinational multiply,
// divide that raises ready a fixed number of cycles after start).
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    localparam int unsigned DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic        mdu_en;
    logic        mdu_clear;
    logic [4:0]  mdu_control;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic [63:0] mdu_result;
    logic        mdu_ready;
    logic        stall_out;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    mdu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .flush       (flush),
        .mthi_we     (mthi_we),
        .mtlo_we     (mtlo_we),
        .wdata       (wdata),
        .mdu_en      (mdu_en),
        .mdu_clear   (mdu_clear),
        .mdu_control (mdu_control),
        .mdu_a       (mdu_a),
        .mdu_b       (mdu_b),
        .mdu_result  (mdu_result),
        .mdu_ready   (mdu_ready),
        .stall_out   (stall_out),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    always #5 clk = ~clk;

    // Behavioural MDU.
    logic [3:0]         m_cnt;
    logic signed [31:0] m_sa;
    logic signed [31:0] m_sb;
    logic               m_is_div;

    assign m_sa     = mdu_a;
    assign m_sb     = mdu_b;
    assign m_is_div = (mdu_control == DIV_CONTROL) || (mdu_control == DIVU_CONTROL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) m_cnt <= '0;
        else if (mdu_en && !mdu_clear && m_is_div) m_cnt <= m_cnt + 4'd1;
        else m_cnt <= '0;
    end

    assign mdu_ready = m_is_div && (m_cnt >= 4'(DIV_LAT));

    always_comb begin
        mdu_result = '0;
        case (mdu_control)
            MULT_CONTROL:  mdu_result = 64'($signed({{32{mdu_a[31]}}, mdu_a}) * $signed({{32{mdu_b[31]}}, mdu_b}));
            MULTU_CONTROL: mdu_result = {32'd0, mdu_a} * {32'd0, mdu_b};
            DIV_CONTROL:   mdu_result = (mdu_b == 32'd0) ? {mdu_a, 32'hFFFF_FFFF}
                                                         : {32'(m_sa % m_sb), 32'(m_sa / m_sb)};
            DIVU_CONTROL:  mdu_result = (mdu_b == 32'd0) ? {mdu_a, 32'hFFFF_FFFF}
                                                         : {mdu_a % mdu_b, mdu_a / mdu_b};
            default:       mdu_result = '0;
        endcase
    end

    // Scoreboard of expected {HI, LO}.
    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] cur_hilo;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
        cur_hilo = v;
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, {hi_o, lo_o}, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_stall"}, 64'(stall_out), 64'd0);
        check_val({tag, "_en"},    64'(mdu_en), 64'd1);
        check_val({tag, "_clear"}, 64'(mdu_clear), 64'd0);
        check_val({tag, "_ctl"},   64'(mdu_control), 64'(MDU_NOP));
        check_val({tag, "_ab"},    {mdu_a, mdu_b}, 64'd0);
        check_val({tag, "_hilo"},  {hi_o, lo_o}, 64'd0);
    endtask

    // Single-cycle multiply; optional simultaneous MTHI to probe write precedence.
    task automatic do_mult(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input logic mt_hi, input logic [31:0] mt_data);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        mthi_we = mt_hi; wdata = mt_data;
        sb_push(tag, exp);
        @(negedge clk);
        check_val({tag, "_stall"}, 64'(stall_out), 64'd0);
        check_val({tag, "_ctl"}, 64'(mdu_control), 64'(op));
        tick();
        req_valid = 1'b0; mthi_we = 1'b0;
        sb_check();
    endtask

    // Divide; counts stall cycles from first request to the ready cycle, returns in DRAIN.
    task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_stall);
        bit accepted = 0;
        bit done     = 0;
        int stalls   = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        sb_push(tag, exp);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (mdu_control != MDU_NOP) accepted = 1;
            if (!stall_out && accepted) begin
                done = 1;
            end else begin
                if (stall_out) stalls++;
                tick();
                if (accepted) req_valid = 1'b0;
            end
        end
        if (!done) check_val({tag, "_timeout"}, 64'd0, 64'd1);
        check_val({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
        tick();
        req_valid = 1'b0;
        sb_check();
        check_val({tag, "_drain"}, {59'd0, mdu_en, mdu_control}, {59'd0, 1'b0, MDU_NOP});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = MDU_NOP; req_a = '0; req_b = '0;
        flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
        cur_hilo = '0;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        do_mult("mult_signed", MULT_CONTROL, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 32'd0);
        do_mult("multu_max", MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 32'd0);

        run_div("div_signed", DIV_CONTROL, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT);
        tick();

        // Back-to-back: second request arrives in DRAIN and pays one extra stall cycle.
        run_div("divu_first", DIVU_CONTROL, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'h7FFF_FFFF}, DIV_LAT);
        run_div("divu_second", DIVU_CONTROL, 32'd9, 32'd4, {32'd1, 32'd2}, DIV_LAT + 1);
        tick();

        run_div("div_negative", DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT);
        tick();
        run_div("divu_by_zero", DIVU_CONTROL, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DIV_LAT);
        tick();

        // Flush in IDLE squashes a multiply.
        req_valid = 1'b1; req_op = MULT_CONTROL; req_a = 32'd3; req_b = 32'd3; flush = 1'b1;
        sb_push("flush_idle_mult", cur_hilo);
        @(negedge clk);
        check_val("flush_idle_clear", {63'd0, mdu_clear}, 64'd1);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        sb_check();

        // Flush in BUSY cycle 3 aborts the divide.
        req_valid = 1'b1; req_op = DIV_CONTROL; req_a = 32'd50; req_b = 32'd3;
        sb_push("flush_busy_hilo", cur_hilo);
        @(negedge clk);
        check_val("flush_issue_stall", 64'(stall_out), 64'd1);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        check_val("flush_busy_clear_stall", {62'd0, mdu_clear, stall_out}, {62'd0, 1'b1, 1'b0});
        tick();
        flush = 1'b0;
        sb_check();
        check_val("flush_idle_state", {58'd0, stall_out, mdu_en, mdu_control},
                  {58'd0, 1'b0, 1'b1, MDU_NOP});

        // MTHI then MTLO.
        mthi_we = 1'b1; wdata = 32'h1234_5678;
        sb_push("mthi", {32'h1234_5678, cur_hilo[31:0]});
        tick();
        mthi_we = 1'b0;
        sb_check();
        mtlo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        sb_push("mtlo", {cur_hilo[63:32], 32'h9ABC_DEF0});
        tick();
        mtlo_we = 1'b0;
        sb_check();

        // Result write beats a simultaneous MTHI.
        do_mult("mult_vs_mthi", MULT_CONTROL, 32'd7, 32'd6, 64'd42, 1'b1, 32'hDEAD_BEEF);

        // Asynchronous reset in the middle of a divide.
        req_valid = 1'b1; req_op = DIV_CONTROL; req_a = 32'd100; req_b = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        check_val("busy_before_reset", 64'(stall_out), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_div");
        #2;
        rst = 1'b1;
        tick();
        cur_hilo = '0;
        do_mult("mult_after_reset", MULT_CONTROL, 32'd3, 32'd4, 64'd12, 1'b0, 32'd0);

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
